// File: rtl/edge_propagator_rx_mc.sv
// rtl/edge_propagator_rx_mc.sv - multi-channel level-to-event receiver with per-channel pending counters
module edge_propagator_rx_mc #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int EDGE_MODE   = 0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_CH-1:0]       valid_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       ready_i,
  input  logic [NUM_CH-1:0]       clr_ovf_i,
  output logic [NUM_CH-1:0]       ack_o,
  output logic [NUM_CH-1:0]       valid_o,
  output logic [NUM_CH*CNT_W-1:0] pending_o,
  output logic [NUM_CH-1:0]       overflow_o
);

  if (NUM_CH < 1 || SYNC_STAGES < 2 || CNT_W < 1 || EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_param_check
    $error("edge_propagator_rx_mc: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   last_stage, rise, fall, evt, inc, dec, sat;

    always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], valid_i[c]};
      last_stage = sync_q[SYNC_STAGES-1];
      prev_d     = last_stage;
      rise       = last_stage & ~prev_q;
      fall       = ~last_stage & prev_q;
      case (EDGE_MODE)
        0:       evt = rise;
        1:       evt = fall;
        default: evt = rise | fall;
      endcase
      inc   = evt & en_i[c];
      dec   = (cnt_q != '0) & ready_i[c];
      sat   = (cnt_q == CNT_MAX);
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_ovf_i[c]) ovf_d = 1'b0;
      // A lost event (saturated inc with no dec) overrides a same-cycle clear.
      if (inc && !dec) begin
        if (sat) ovf_d = 1'b1;
        else     cnt_d = cnt_q + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sync_q <= '0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        prev_q <= prev_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
      end
    end

    assign ack_o[c]                    = sync_q[SYNC_STAGES-1];
    assign valid_o[c]                  = (cnt_q != '0);
    assign pending_o[c*CNT_W +: CNT_W] = cnt_q;
    assign overflow_o[c]               = ovf_q;
  end

endmodule

// File: tb/tb_edge_propagator_rx_mc.sv
// tb/tb_edge_propagator_rx_mc.sv - bench for edge_propagator_rx_mc: three parameterisations, directed and random
module tb_edge_propagator_rx_mc;

  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [3:0] v, en, rdy, clr;

  logic [3:0]  ack_a, vo_a, ov_a;
  logic [15:0] pd_a;
  logic [3:0]  ack_b, vo_b, ov_b;
  logic [15:0] pd_b;
  logic [3:0]  ack_c, vo_c, ov_c;
  logic [7:0]  pd_c;

  edge_propagator_rx_mc dut_a (
    .clk_i(clk), .rstn_i(rstn), .valid_i(v), .en_i(en), .ready_i(rdy), .clr_ovf_i(clr),
    .ack_o(ack_a), .valid_o(vo_a), .pending_o(pd_a), .overflow_o(ov_a)
  );

  edge_propagator_rx_mc #(.EDGE_MODE(2)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .valid_i(v), .en_i(en), .ready_i(rdy), .clr_ovf_i(clr),
    .ack_o(ack_b), .valid_o(vo_b), .pending_o(pd_b), .overflow_o(ov_b)
  );

  edge_propagator_rx_mc #(.CNT_W(2)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .valid_i(v), .en_i(en), .ready_i(rdy), .clr_ovf_i(clr),
    .ack_o(ack_c), .valid_o(vo_c), .pending_o(pd_c), .overflow_o(ov_c)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ack is valid_i seen SYNC_STAGES-1 edges back, an event is a change of
  // that delayed level, and each config keeps a saturating integer count.
  logic [3:0] vq[$];
  int         cnt[3][4];
  bit         ovf[3][4];
  int         mode[3] = '{0, 2, 0};
  int         cmax[3] = '{15, 15, 3};
  int         cw[3]   = '{4, 4, 2};

  task automatic model_reset();
    vq = {};
    for (int k = 0; k <= S; k++) vq.push_front(4'b0);
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < 4; c++) begin
        cnt[m][c] = 0;
        ovf[m][c] = 0;
      end
  endtask

  task automatic model_step();
    logic [3:0] a, p;
    bit r, f, ev, inc, dec, set;
    a = vq[S-1];
    p = vq[S];
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < 4; c++) begin
        r   = a[c] && !p[c];
        f   = !a[c] && p[c];
        ev  = (mode[m] == 0) ? r : (mode[m] == 1) ? f : (r || f);
        inc = ev && en[c];
        dec = (cnt[m][c] > 0) && rdy[c];
        set = 0;
        if (inc && !dec) begin
          if (cnt[m][c] == cmax[m]) set = 1;
          else cnt[m][c] = cnt[m][c] + 1;
        end else if (dec && !inc) begin
          cnt[m][c] = cnt[m][c] - 1;
        end
        ovf[m][c] = set ? 1'b1 : (clr[c] ? 1'b0 : ovf[m][c]);
      end
    vq.push_front(v);
    void'(vq.pop_back());
  endtask

  function automatic logic [31:0] m_pend(int m);
    logic [31:0] r = '0;
    for (int c = 0; c < 4; c++) r = r | (32'(cnt[m][c]) << (c * cw[m]));
    return r;
  endfunction

  function automatic logic [31:0] m_vo(int m);
    logic [31:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = (cnt[m][c] != 0);
    return r;
  endfunction

  function automatic logic [31:0] m_ovf(int m);
    logic [31:0] r = '0;
    for (int c = 0; c < 4; c++) r[c] = ovf[m][c];
    return r;
  endfunction

  always @(posedge clk) if (rstn) model_step();
  always @(negedge rstn) model_reset();

  always @(negedge clk) if (chk_en) begin
    chk("a_ack", 32'(ack_a), 32'(vq[S-1]));
    chk("a_valid", 32'(vo_a), m_vo(0));
    chk("a_pend", 32'(pd_a), m_pend(0));
    chk("a_ovf", 32'(ov_a), m_ovf(0));
    chk("b_ack", 32'(ack_b), 32'(vq[S-1]));
    chk("b_valid", 32'(vo_b), m_vo(1));
    chk("b_pend", 32'(pd_b), m_pend(1));
    chk("b_ovf", 32'(ov_b), m_ovf(1));
    chk("c_ack", 32'(ack_c), 32'(vq[S-1]));
    chk("c_valid", 32'(vo_c), m_vo(2));
    chk("c_pend", 32'(pd_c), m_pend(2));
    chk("c_ovf", 32'(ov_c), m_ovf(2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v = '0; rdy = '0; clr = '0; en = 4'hF;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic toggle(int c);
    v[c] = ~v[c];
    for (int k = 0; k < 10 && ack_a[c] !== v[c]; k++) step();
    chk($sformatf("handshake_ch%0d", c), 32'(ack_a[c]), 32'(v[c]));
  endtask

  typedef struct {
    logic [3:0]  v, en, rdy, clr;
    logic [3:0]  ack, vo, ovf;
    logic [15:0] pend;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    v = '0; en = '0; rdy = '0; clr = '0; rstn = 1'b0;
    model_reset();
    chk_en = 1;
    step(); step();
    chk("rst_ack", 32'(ack_a), 0);
    chk("rst_valid", 32'(vo_a), 0);
    chk("rst_pend", 32'(pd_a), 0);
    chk("rst_ovf", 32'(ov_a), 0);
    rstn = 1'b1;

    // ch0 rising event on the default config, then drain, then a falling change that must not count
    tbl[0] = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[1] = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0000};
    tbl[2] = '{4'h1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 16'h0001};
    tbl[3] = '{4'h1, 4'hF, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0000};
    tbl[4] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 16'h0000};
    tbl[5] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[6] = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000};
    for (int i = 0; i < 7; i++) begin
      v = tbl[i].v; en = tbl[i].en; rdy = tbl[i].rdy; clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_ack", i), 32'(ack_a), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_valid", i), 32'(vo_a), 32'(tbl[i].vo));
      chk($sformatf("tbl%0d_pend", i), 32'(pd_a), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_ovf", i), 32'(ov_a), 32'(tbl[i].ovf));
    end

    // both-edge config: four toggles on ch2 then drain one per cycle
    do_reset();
    for (int i = 0; i < 4; i++) toggle(2);
    step(); step();
    chk("b_ch2_pend4", 32'(pd_b[11:8]), 4);
    rdy = 4'h4;
    for (int i = 3; i >= 0; i--) begin
      step();
      chk($sformatf("b_ch2_drain%0d", i), 32'(pd_b[11:8]), 32'(i));
    end
    chk("b_ch2_valid_low", 32'(vo_b[2]), 0);
    rdy = '0;

    // 2-bit counter: saturation, overflow, clear, clear losing to a same-edge set
    do_reset();
    for (int i = 0; i < 3; i++) begin toggle(0); toggle(0); end
    chk("c_sat_pend3", 32'(pd_c[1:0]), 3);
    chk("c_no_ovf_yet", 32'(ov_c[0]), 0);
    toggle(0); toggle(0);
    chk("c_sat_hold", 32'(pd_c[1:0]), 3);
    chk("c_ovf_set", 32'(ov_c[0]), 1);
    clr = 4'h1; step(); clr = '0;
    chk("c_ovf_clr", 32'(ov_c[0]), 0);
    v[0] = 1'b1; step(); step();
    clr = 4'h1; step(); clr = '0;
    chk("c_ovf_set_wins", 32'(ov_c[0]), 1);
    step();
    chk("c_ovf_sticky", 32'(ov_c[0]), 1);
    chk("c_pend_still3", 32'(pd_c[1:0]), 3);
    toggle(0);

    // simultaneous inc/dec holds, and disabled channel discards events
    do_reset();
    toggle(1); toggle(1); toggle(1); toggle(1);
    step();
    chk("a_ch1_pend2", 32'(pd_a[7:4]), 2);
    v[1] = 1'b1; step(); step();
    rdy = 4'h2; step(); rdy = '0;
    chk("a_ch1_incdec", 32'(pd_a[7:4]), 2);
    toggle(1);
    en[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin toggle(1); toggle(1); end
    step(); step();
    chk("a_ch1_en0_pend", 32'(pd_a[7:4]), 2);
    chk("a_ch1_en0_ovf", 32'(ov_a[1]), 0);
    en = 4'hF;

    // reset mid-drain, valid held high across reset yields exactly one event
    do_reset();
    toggle(3); toggle(3); toggle(3); toggle(3); toggle(3);
    step(); step();
    chk("a_ch3_pend3", 32'(pd_a[15:12]), 3);
    rdy = 4'h8; step();
    chk("a_ch3_drain", 32'(pd_a[15:12]), 2);
    rstn = 1'b0; rdy = '0;
    #1;
    chk("async_rst_ack", 32'({ack_a, ack_b, ack_c}), 0);
    chk("async_rst_valid", 32'({vo_a, vo_b, vo_c}), 0);
    chk("async_rst_pend", 32'({pd_a, pd_b, pd_c}), 0);
    chk("async_rst_ovf", 32'({ov_a, ov_b, ov_c}), 0);
    step();
    rstn = 1'b1;
    step();
    chk("rel_e1_pend", 32'(pd_a[15:12]), 0);
    step();
    chk("rel_e2_ack", 32'(ack_a[3]), 1);
    chk("rel_e2_pend", 32'(pd_a[15:12]), 0);
    step();
    chk("rel_e3_pend", 32'(pd_a[15:12]), 1);
    step(); step();
    chk("rel_one_event", 32'(pd_a[15:12]), 1);

    // random traffic against the model, with occasional one-cycle resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v    = v ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      en   = 4'($urandom) | 4'($urandom);
      rdy  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      clr  = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      rstn = ($urandom_range(0, 499) != 0);
      step();
    end
    rstn = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_propagator_rx_mc.md
EDGE_PROPAGATOR_RX_MC -- requirements
Module: edge_propagator_rx_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent receive channels, >=1.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, >=2.
REQ-003 The block SHALL have parameter CNT_W, default 4: width of the per-channel pending-event counter, >=1.
REQ-004 The block SHALL have parameter EDGE_MODE, default 0: 0 = rising, 1 = falling, 2 = both edges generate events.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single receive-domain clock.
REQ-006 The block SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port valid_i, input, NUM_CH bits: per-channel level from the transmit domain, asynchronous to clk_i.
REQ-008 The block SHALL have port en_i, input, NUM_CH bits: per-channel event enable.
REQ-009 The block SHALL have port ready_i, input, NUM_CH bits: per-channel consumer accepts one event.
REQ-010 The block SHALL have port clr_ovf_i, input, NUM_CH bits: per-channel clear of the overflow flag.
REQ-011 The block SHALL have port ack_o, output, NUM_CH bits: synchronised copy of valid_i, returned to the transmitter.
REQ-012 The block SHALL have port valid_o, output, NUM_CH bits: at least one event pending on the channel.
REQ-013 The block SHALL have port pending_o, output, NUM_CH*CNT_W bits: per-channel pending count; channel c occupies bits [c*CNT_W +: CNT_W].
REQ-014 The block SHALL have port overflow_o, output, NUM_CH bits: sticky flag, an event was lost to saturation.

Function
REQ-015 Each channel SHALL pass valid_i through SYNC_STAGES flops; ack_o SHALL equal the last stage.
REQ-016 A change on valid_i, stable before clock edge 1, SHALL appear on ack_o after edge SYNC_STAGES.
REQ-017 A prev register SHALL hold the last stage delayed by one cycle.
REQ-018 Rising event = last stage 1 and prev 0; falling event = last stage 0 and prev 1; EDGE_MODE selects which of these count, and mode 2 counts both.
REQ-019 inc SHALL be event AND en_i; dec SHALL be valid_o AND ready_i.
REQ-020 An event SHALL update pending at edge SYNC_STAGES+1, so valid_o rises at that edge.
REQ-021 Counter update rules:
- inc and not dec: +1
- dec and not inc: -1
- inc and dec together: unchanged
- neither: unchanged
REQ-022 valid_o SHALL equal (pending != 0), combinationally from the counter register.
REQ-023 Saturation: at 2^CNT_W-1 with inc and no dec, the counter SHALL hold and overflow_o SHALL set on that edge.
REQ-024 Saturation with inc and dec together: the counter SHALL stay unchanged and no overflow SHALL be flagged.
REQ-025 ready_i while pending==0 SHALL have no effect; the counter SHALL never wrap below 0.
REQ-026 overflow_o SHALL stay set until clr_ovf_i is sampled high; if set and clear coincide, set SHALL win.
REQ-027 With en_i low, events SHALL be discarded without counting or overflow, while pending SHALL keep draining and ack_o SHALL keep tracking.
REQ-028 Channels SHALL be fully independent; no cross-channel arbitration or ordering is provided.
REQ-029 Protocol: the transmitter SHALL NOT change valid_i until ack_o equals the previous value; on violation, events may be lost, but no output SHALL go X and no state SHALL lock up.
REQ-030 Illegal parameter values (SYNC_STAGES<2, NUM_CH<1, CNT_W<1, EDGE_MODE>2) SHALL abort elaboration.

Reset
REQ-031 While rstn_i is low, all sync flops, prev, counters and overflow flags SHALL be 0, giving ack_o=0, valid_o=0, pending_o=0, overflow_o=0.
REQ-032 Reset SHALL take effect asynchronously and be released synchronously to clk_i.
REQ-033 Asserting reset mid-operation SHALL discard all pending events immediately.
REQ-034 If valid_i is already high at reset release, it SHALL produce one rising event (prev resets to 0).

Verification
REQ-035 Defaults, ch0 valid_i 0->1 before edge 1, en=1, ready=0 -> ack_o[0]=1 after edge 2, valid_o[0]=1 and pending 1 after edge 3; channels 1-3 stay 0.
REQ-036 EDGE_MODE=2, ch2 four handshaked toggles with ready=0 -> pending 4; then ready=1 for 4 cycles -> 3,2,1,0, with valid_o low after the 4th.
REQ-037 CNT_W=2, 4 rising events with ready=0 -> pending saturates at 3 and overflow_o sets on the 4th; clr_ovf_i pulsed alone -> overflow clears; clr coinciding with a 5th event -> overflow stays 1.
REQ-038 pending=2 with an event and ready=1 in the same cycle -> pending stays 2; en_i=0 with 3 events -> pending unchanged and overflow unchanged.
REQ-039 rstn_i low for one cycle mid-drain with pending=3 -> all outputs 0 immediately; valid_i held high across reset -> exactly one event after release+SYNC_STAGES+1 edges.
